timer_core: RTL and testbench

- Parametrised successor of the board's minutes:seconds countdown controller+counter.
- Merges control FSM and BCD time counter into one block.
- Adds: selectable count direction (countdown or stopwatch), held-button auto-repeat in set modes, DONE state with blinking alarm, reload of last start value.
- Sits between the Debouncer array (inputs) and Seg_7_Display/LEDs (outputs).

---
 rtl/timer_pkg.sv | 29 ++
 rtl/bcd_mmss_counter.sv | 71 +++++++
 rtl/timer_core.sv | 182 ++++++++++++++++++
 tb/tb_timer_core.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the mm:ss timer: one-hot states, BCD limits and digit helpers.
package timer_pkg;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_SET_MIN = 5'b00010,
    S_SET_SEC = 5'b00100,
    S_RUN     = 5'b01000,
    S_DONE    = 5'b10000
  } state_e;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [7:0] SEC_MAX_BCD  = {SEC_TENS_MAX, DIGIT_MAX};

  // Binary 0..99 to two BCD digits.
  function automatic logic [7:0] bin2bcd8(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    return (v[3:0] == DIGIT_MAX) ? {4'(v[7:4] + 4'd1), 4'd0} : {v[7:4], 4'(v[3:0] + 4'd1)};
  endfunction

  function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {4'(v[7:4] - 4'd1), DIGIT_MAX} : {v[7:4], 4'(v[3:0] - 4'd1)};
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD mm:ss register with load, per-field wrap steps and carry/borrow seconds steps.
module bcd_mmss_counter
  import timer_pkg::*;
#(
  parameter int unsigned MIN_MAX  = 99,
  parameter int unsigned INIT_MIN = 0,
  parameter int unsigned INIT_SEC = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_en,
  input  logic [15:0] load_val,
  input  logic        fld_en,
  input  logic        fld_sec,
  input  logic        fld_up,
  input  logic        full_en,
  input  logic        full_up,
  output logic [15:0] time_bcd,
  output logic        is_zero,
  output logic        dn_to_zero_c,
  output logic        up_to_max_c
);

  localparam logic [7:0] MIN_MAX_BCD  = bin2bcd8(MIN_MAX);
  localparam logic [7:0] INIT_MIN_BCD = bin2bcd8(INIT_MIN);
  localparam logic [7:0] INIT_SEC_BCD = bin2bcd8(INIT_SEC);

  logic [7:0]  min_q, min_d, sec_q, sec_d;
  logic [7:0]  min_inc, min_dec, sec_inc, sec_dec;
  logic [15:0] full_inc, full_dec;
  logic        is_zero_q, is_zero_d;

  always_comb begin
    min_inc  = (min_q == MIN_MAX_BCD) ? 8'h00 : bcd_inc8(min_q);
    min_dec  = (min_q == 8'h00) ? MIN_MAX_BCD : bcd_dec8(min_q);
    sec_inc  = (sec_q == SEC_MAX_BCD) ? 8'h00 : bcd_inc8(sec_q);
    sec_dec  = (sec_q == 8'h00) ? SEC_MAX_BCD : bcd_dec8(sec_q);
    full_inc = (sec_q == SEC_MAX_BCD) ? {min_inc, 8'h00} : {min_q, sec_inc};
    full_dec = (sec_q == 8'h00) ? {min_dec, SEC_MAX_BCD} : {min_q, sec_dec};
    min_d    = min_q;
    sec_d    = sec_q;
    if (load_en) begin
      {min_d, sec_d} = load_val;
    end else if (full_en) begin
      {min_d, sec_d} = full_up ? full_inc : full_dec;
    end else if (fld_en && fld_sec) begin
      sec_d = fld_up ? sec_inc : sec_dec;
    end else if (fld_en) begin
      min_d = fld_up ? min_inc : min_dec;
    end
    is_zero_d = ({min_d, sec_d} == 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      min_q     <= INIT_MIN_BCD;
      sec_q     <= INIT_SEC_BCD;
      is_zero_q <= ({INIT_MIN_BCD, INIT_SEC_BCD} == 16'h0000);
    end else begin
      min_q     <= min_d;
      sec_q     <= sec_d;
      is_zero_q <= is_zero_d;
    end
  end

  assign time_bcd     = {min_q, sec_q};
  assign is_zero      = is_zero_q;
  assign dn_to_zero_c = (full_dec == 16'h0000);
  assign up_to_max_c  = (full_inc == {MIN_MAX_BCD, SEC_MAX_BCD});

endmodule

// File: rtl/timer_core.sv
// mm:ss countdown/stopwatch controller: button edges, auto-repeat, prescaler and run/alarm FSM.
module timer_core
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100000000,
  parameter int unsigned MIN_MAX      = 99,
  parameter int unsigned INIT_MIN     = 0,
  parameter int unsigned INIT_SEC     = 0,
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 10000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dir,
  input  logic        trig,
  input  logic        set,
  input  logic        up,
  input  logic        down,
  output logic [15:0] time_bcd,
  output logic [4:0]  state,
  output logic        complete,
  output logic        alarm
);

  localparam int unsigned PRE_W   = $clog2(TICK_DIV);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TICK_DIV / 2 - 1);
  localparam logic [REP_W-1:0] REP_DLY  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RATE = REP_W'(REPEAT_RATE);
  localparam logic [15:0]      INIT_BCD = {bin2bcd8(INIT_MIN), bin2bcd8(INIT_SEC)};
  localparam int unsigned B_TRIG = 3, B_SET = 2, B_UP = 1, B_DN = 0;

  state_e           state_q, state_d;
  logic [3:0]       btn_lvl_q, btn_lvl_d, btn_prs_q, btn_prs_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_arm_q, rep_arm_d;
  logic             run_dir_q, run_dir_d;
  logic [15:0]      load_q, load_d;
  logic             complete_q, complete_d, alarm_q, alarm_d;
  logic             cnt_load, fld_en, fld_sec, fld_up, full_en;
  logic             is_zero, dn_to_zero_c, up_to_max_c, start_go;

  assign fld_sec  = (state_q == S_SET_SEC);
  assign fld_up   = btn_lvl_q[B_UP];
  assign start_go = btn_prs_q[B_TRIG] & (dir | ~is_zero);

  always_comb begin
    btn_lvl_d  = {trig, set, up, down};
    btn_prs_d  = {trig, set, up, down} & ~btn_lvl_q;
    state_d    = state_q;
    presc_d    = presc_q;
    rep_cnt_d  = '0;
    rep_arm_d  = 1'b0;
    run_dir_d  = run_dir_q;
    load_d     = load_q;
    complete_d = 1'b0;
    alarm_d    = 1'b0;
    cnt_load   = 1'b0;
    fld_en     = 1'b0;
    full_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d   = S_RUN;
          load_d    = time_bcd;
          run_dir_d = dir;
        end else if (btn_prs_q[B_SET] && !btn_prs_q[B_TRIG]) begin
          state_d = S_SET_MIN;
        end
      end
      S_SET_MIN, S_SET_SEC: begin
        if (start_go) begin
          state_d   = S_RUN;
          load_d    = time_bcd;
          run_dir_d = dir;
        end else begin
          if (btn_prs_q[B_SET] && !btn_prs_q[B_TRIG])
            state_d = (state_q == S_SET_MIN) ? S_SET_SEC : S_SET_MIN;
          // Repeat only follows a press step, and only while exactly one of up/down is held.
          if (btn_lvl_q[B_UP] ^ btn_lvl_q[B_DN]) begin
            if (btn_prs_q[B_UP] | btn_prs_q[B_DN]) begin
              fld_en    = 1'b1;
              rep_cnt_d = REP_W'(1);
            end else if (rep_cnt_q != '0) begin
              if (rep_cnt_q == (rep_arm_q ? REP_RATE : REP_DLY)) begin
                fld_en    = 1'b1;
                rep_cnt_d = REP_W'(1);
                rep_arm_d = 1'b1;
              end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
                rep_arm_d = rep_arm_q;
              end
            end
          end
        end
      end
      S_RUN: begin
        if (btn_prs_q[B_TRIG]) begin
          state_d = S_SET_MIN;
        end else if (presc_q == PRE_TERM) begin
          presc_d = '0;
          full_en = 1'b1;
          if (run_dir_q ? up_to_max_c : dn_to_zero_c) begin
            state_d    = S_DONE;
            complete_d = 1'b1;
            alarm_d    = 1'b1;
          end
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      S_DONE: begin
        if (btn_prs_q[B_TRIG] | btn_prs_q[B_SET]) begin
          state_d  = S_IDLE;
          cnt_load = 1'b1;
          presc_d  = '0;
        end else if (presc_q == PRE_HALF) begin
          presc_d = '0;
          alarm_d = ~alarm_q;
        end else begin
          presc_d = presc_q + PRE_W'(1);
          alarm_d = alarm_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      btn_lvl_q  <= '0;
      btn_prs_q  <= '0;
      presc_q    <= '0;
      rep_cnt_q  <= '0;
      rep_arm_q  <= 1'b0;
      run_dir_q  <= 1'b0;
      load_q     <= INIT_BCD;
      complete_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_lvl_q  <= btn_lvl_d;
      btn_prs_q  <= btn_prs_d;
      presc_q    <= presc_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_arm_q  <= rep_arm_d;
      run_dir_q  <= run_dir_d;
      load_q     <= load_d;
      complete_q <= complete_d;
      alarm_q    <= alarm_d;
    end
  end

  bcd_mmss_counter #(
    .MIN_MAX (MIN_MAX),
    .INIT_MIN(INIT_MIN),
    .INIT_SEC(INIT_SEC)
  ) u_cnt (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_en     (cnt_load),
    .load_val    (load_q),
    .fld_en      (fld_en),
    .fld_sec     (fld_sec),
    .fld_up      (fld_up),
    .full_en     (full_en),
    .full_up     (run_dir_q),
    .time_bcd    (time_bcd),
    .is_zero     (is_zero),
    .dn_to_zero_c(dn_to_zero_c),
    .up_to_max_c (up_to_max_c)
  );

  assign state    = state_q;
  assign complete = complete_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core: directed walk with literal expectations, then random buttons vs. an mm:ss model.
module tb_timer_core;

  localparam int unsigned TD = 4, MM = 99, RD = 8, RR = 2;
  localparam int TOTAL_SECS = (MM + 1) * 60;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        dir = 1'b0, trig = 1'b0, set = 1'b0, up = 1'b0, down = 1'b0;
  logic [15:0] time_bcd;
  logic [4:0]  state;
  logic        complete, alarm;

  int total = 0, bad = 0;

  // Model: states 0 IDLE, 1 SET_MIN, 2 SET_SEC, 3 RUN, 4 DONE; time as plain integers.
  int m_st = 0, m_mm = 0, m_ss = 0, l_mm = 0, l_ss = 0, m_tick = 0, m_dc = 0, rep_len = 0;
  bit m_rdir = 0, m_cmp = 0, rep_act = 0, armed = 0;
  bit pl_trig = 0, pl_set = 0, pl_up = 0, pl_dn = 0, pp_trig = 0, pp_set = 0, pp_up = 0, pp_dn = 0;

  timer_core #(
    .TICK_DIV(TD), .MIN_MAX(MM), .INIT_MIN(0), .INIT_SEC(0),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dir(dir), .trig(trig), .set(set), .up(up), .down(down),
    .time_bcd(time_bcd), .state(state), .complete(complete), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic go_run();
    m_st = 3; l_mm = m_mm; l_ss = m_ss; m_rdir = dir; rep_act = 0;
  endtask

  task automatic field_step(input int fld, input bit inc);
    if (fld == 2) m_ss = inc ? (m_ss + 1) % 60 : (m_ss + 59) % 60;
    else          m_mm = inc ? (m_mm + 1) % (MM + 1) : (m_mm + MM) % (MM + 1);
  endtask

  task automatic model_step();
    int  tot, fld;
    bit  tp, sp, stp, start_ok;
    if (!reset_n) begin
      armed = 1; m_st = 0; m_mm = 0; m_ss = 0; l_mm = 0; l_ss = 0; m_tick = 0; m_dc = 0;
      m_rdir = 0; m_cmp = 0; rep_act = 0; rep_len = 0;
      {pl_trig, pl_set, pl_up, pl_dn, pp_trig, pp_set, pp_up, pp_dn} = '0;
      return;
    end
    tp = pp_trig; sp = pp_set; m_cmp = 0;
    start_ok = (dir == 1'b1) || (m_mm != 0) || (m_ss != 0);
    if (m_st != 1 && m_st != 2) rep_act = 0;
    case (m_st)
      0: if (tp && start_ok) go_run(); else if (sp && !tp) m_st = 1;
      1, 2: begin
        if (tp && start_ok) go_run();
        else begin
          fld = m_st;
          if (sp && !tp) m_st = (m_st == 1) ? 2 : 1;
          if (pl_up != pl_dn) begin
            stp = 0;
            if (pp_up || pp_dn) begin stp = 1; rep_act = 1; rep_len = 0; end
            else if (rep_act) begin
              rep_len++;
              stp = (rep_len == RD) || (rep_len > RD && (rep_len - RD) % RR == 0);
            end
            if (stp) field_step(fld, pl_up);
          end else rep_act = 0;
        end
      end
      3: begin
        if (tp) m_st = 1;
        else if (m_tick == TD - 1) begin
          m_tick = 0;
          tot = m_mm * 60 + m_ss;
          tot = m_rdir ? (tot + 1) % TOTAL_SECS : (tot + TOTAL_SECS - 1) % TOTAL_SECS;
          m_mm = tot / 60; m_ss = tot % 60;
          if (m_rdir ? (tot == TOTAL_SECS - 1) : (tot == 0)) begin m_st = 4; m_cmp = 1; m_dc = 0; end
        end else m_tick++;
      end
      default: if (tp || sp) begin m_st = 0; m_mm = l_mm; m_ss = l_ss; m_tick = 0; end else m_dc++;
    endcase
    pp_trig = trig & ~pl_trig; pp_set = set & ~pl_set; pp_up = up & ~pl_up; pp_dn = down & ~pl_dn;
    pl_trig = trig; pl_set = set; pl_up = up; pl_dn = down;
  endtask

  // Per-cycle comparison of every output against the model.
  always begin
    @(posedge clk);
    model_step();
    #1;
    if (armed) begin
      chk("time", time_bcd, bcd(m_mm, m_ss));
      chk("state", 16'(state), 16'(5'b00001 << m_st));
      chk("complete", 16'(complete), 16'(m_cmp));
      chk("alarm", 16'(alarm), 16'((m_st == 4) && ((m_dc / (TD / 2)) % 2 == 0)));
    end
  end

  task automatic press(input int which);
    case (which)
      0: trig = 1'b1;
      1: set  = 1'b1;
      2: up   = 1'b1;
      default: down = 1'b1;
    endcase
    @(negedge clk);
    trig = 1'b0; set = 1'b0; up = 1'b0; down = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int phase;
    wait_n(2);
    reset_n = 1'b1;
    chk("rst_time", time_bcd, 16'h0000);
    chk("rst_state", 16'(state), 16'h0001);
    chk("rst_complete", 16'(complete), 16'h0000);
    chk("rst_alarm", 16'(alarm), 16'h0000);
    press(0);
    chk("zero_start_ignored", 16'(state), 16'h0001);
    press(1); press(3);
    chk("min_wrap_down", time_bcd, 16'h9900);
    press(1); press(3); press(3);
    chk("sec_wrap_down", time_bcd, 16'h9958);
    chk("set_sec_state", 16'(state), 16'h0004);
    up = 1'b1; down = 1'b1; wait_n(4); up = 1'b0; down = 1'b0; wait_n(2);
    chk("up_down_together", time_bcd, 16'h9958);
    press(1); press(2); press(1); press(2); press(2); press(2); press(2);
    chk("set_0002", time_bcd, 16'h0002);
    dir = 1'b0; press(0);
    chk("run_state", 16'(state), 16'h0008);
    wait_n(4); chk("cd_0001", time_bcd, 16'h0001);
    wait_n(4); chk("cd_0000", time_bcd, 16'h0000);
    chk("done_state", 16'(state), 16'h0010);
    chk("complete_pulse", 16'(complete), 16'h0001);
    chk("alarm_first", 16'(alarm), 16'h0001);
    wait_n(1); chk("complete_drop", 16'(complete), 16'h0000);
    chk("alarm_hold", 16'(alarm), 16'h0001);
    wait_n(1); chk("alarm_toggle", 16'(alarm), 16'h0000);
    press(0);
    chk("reload_0002", time_bcd, 16'h0002);
    chk("back_idle", 16'(state), 16'h0001);
    press(1); press(1); press(3); press(3); press(3);
    chk("set_0059", time_bcd, 16'h0059);
    dir = 1'b1; press(0);
    wait_n(4); chk("carry_0100", time_bcd, 16'h0100);
    wait_n(1); press(0);
    chk("pause_state", 16'(state), 16'h0002);
    wait_n(5); chk("pause_frozen", time_bcd, 16'h0100);
    press(0);
    wait_n(1); chk("resume_early", time_bcd, 16'h0100);
    wait_n(1); chk("resume_step", time_bcd, 16'h0101);
    reset_n = 1'b0; wait_n(1);
    chk("midrun_rst_time", time_bcd, 16'h0000);
    chk("midrun_rst_state", 16'(state), 16'h0001);
    reset_n = 1'b1;
    press(1); press(3); press(1); press(3); press(3);
    press(0);
    wait_n(4); chk("up_max_9959", time_bcd, 16'h9959);
    chk("up_done_state", 16'(state), 16'h0010);
    press(1);
    chk("up_reload_9958", time_bcd, 16'h9958);
    press(1); press(2); press(1); press(2); press(2);
    chk("rep_start", time_bcd, 16'h0000);
    up = 1'b1; wait_n(2);
    chk("rep_press", time_bcd, 16'h0001);
    wait_n(7); chk("rep_before_delay", time_bcd, 16'h0001);
    wait_n(1); chk("rep_delay", time_bcd, 16'h0002);
    wait_n(2); chk("rep_rate1", time_bcd, 16'h0003);
    wait_n(2); chk("rep_rate2", time_bcd, 16'h0004);
    wait_n(2); chk("rep_rate3", time_bcd, 16'h0005);
    up = 1'b0; wait_n(3);
    chk("rep_release", time_bcd, 16'h0005);

    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      phase = (i / 512) % 2;
      reset_n = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, (phase != 0) ? 200 : 15) == 0) trig = ~trig;
      if ($urandom_range(0, 11) == 0) set = ~set;
      if ($urandom_range(0, (phase != 0) ? 19 : 5) == 0) up = ~up;
      if ($urandom_range(0, (phase != 0) ? 29 : 7) == 0) down = ~down;
      if ($urandom_range(0, 63) == 0) dir = ~dir;
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
